// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared mode encoding and helpers for the CPU execution controller
package cpu_ctrl_pkg;

  localparam logic [1:0] MODE_STEP  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_BREAK = 2'b10;

  // State values equal the MODE encoding so MODE can come straight off the state flops.
  typedef enum logic [1:0] {
    ST_STEP  = MODE_STEP,
    ST_RUN   = MODE_RUN,
    ST_BREAK = MODE_BREAK
  } state_e;

  function automatic logic bp_hit(input logic        bp_en,
                                  input logic [31:0] pc,
                                  input logic [31:0] bp_addr,
                                  input logic        bypass);
    return bp_en && (pc == bp_addr) && !bypass;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer, stable-sample debouncer and press pulse
module btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic CCLK,
  input  logic RST_N,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int            CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  // The count only advances while the synchronized sample disagrees with the clean level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - single-step / free-run / breakpoint clock-enable controller
module cpu_step_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int RUN_DIV   = 1
) (
  input  logic        CCLK,
  input  logic        RST_N,
  input  logic        BTN_STEP,
  input  logic        BTN_RUN,
  input  logic        BP_EN,
  input  logic [31:0] BP_ADDR,
  input  logic [31:0] PC,
  output logic        CPU_EN,
  output logic [1:0]  MODE,
  output logic [31:0] STEP_CNT
);

  localparam logic [15:0] DIV_LAST = 16'(RUN_DIV - 1);

  logic step_press, run_press;
  logic step_level_unused, run_level_unused;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
    .CCLK (CCLK),
    .RST_N(RST_N),
    .raw  (BTN_STEP),
    .level(step_level_unused),
    .press(step_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
    .CCLK (CCLK),
    .RST_N(RST_N),
    .raw  (BTN_RUN),
    .level(run_level_unused),
    .press(run_press)
  );

  state_e      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic        bypass_q, bypass_d;
  logic        cpu_en_q, cpu_en_d;
  logic [31:0] step_cnt_q, step_cnt_d;
  logic        due;

  // Run press is tested first in every state, so it wins over a same-cycle step press.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bypass_d = bypass_q;
    cpu_en_d = 1'b0;
    due      = (div_q == DIV_LAST);
    unique case (state_q)
      ST_STEP: begin
        if (run_press) begin
          state_d  = ST_RUN;
          div_d    = '0;
          bypass_d = 1'b0;
        end else if (step_press) begin
          cpu_en_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (run_press) begin
          state_d = ST_STEP;
          div_d   = '0;
        end else begin
          div_d = due ? 16'd0 : div_q + 16'd1;
          if (due) begin
            if (bp_hit(BP_EN, PC, BP_ADDR, bypass_q)) begin
              state_d = ST_BREAK;
            end else begin
              cpu_en_d = 1'b1;
              bypass_d = 1'b0;
            end
          end
        end
      end
      ST_BREAK: begin
        // Resuming with the bypass set lets the pipeline step off the breakpoint PC once.
        if (run_press) begin
          state_d  = ST_RUN;
          div_d    = '0;
          bypass_d = 1'b1;
        end else if (step_press) begin
          state_d  = ST_STEP;
          cpu_en_d = 1'b1;
        end
      end
      default: state_d = ST_STEP;
    endcase
    step_cnt_d = step_cnt_q + {31'd0, cpu_en_d};
  end

  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_STEP;
      div_q      <= '0;
      bypass_q   <= 1'b0;
      cpu_en_q   <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bypass_q   <= bypass_d;
      cpu_en_q   <= cpu_en_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign CPU_EN   = cpu_en_q;
  assign MODE     = state_q;
  assign STEP_CNT = step_cnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb/tb_cpu_step_ctrl.sv - scoreboard bench for cpu_step_ctrl (DB_CYCLES=4, RUN_DIV=2 and 1)
module tb_cpu_step_ctrl;
  import cpu_ctrl_pkg::*;

  typedef struct {
    int          cyc;
    logic [31:0] cnt;
    logic [1:0]  mode;
    logic [31:0] pc;
  } exp_t;

  logic        clk;
  logic        rst_n, btn_step, btn_run, bp_en;
  logic [31:0] bp_addr, pc;
  logic        cpu_en;
  logic [1:0]  mode;
  logic [31:0] step_cnt;

  logic        rst1_n, btn_step1, btn_run1, bp_en1;
  logic [31:0] bp_addr1, pc1;
  logic        cpu_en1;
  logic [1:0]  mode1;
  logic [31:0] step_cnt1;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   pc_adv = 1'b1;
  exp_t sbq[$];

  cpu_step_ctrl #(.DB_CYCLES(4), .RUN_DIV(2)) dut (
    .CCLK(clk), .RST_N(rst_n), .BTN_STEP(btn_step), .BTN_RUN(btn_run),
    .BP_EN(bp_en), .BP_ADDR(bp_addr), .PC(pc),
    .CPU_EN(cpu_en), .MODE(mode), .STEP_CNT(step_cnt)
  );

  cpu_step_ctrl #(.DB_CYCLES(4), .RUN_DIV(1)) dut1 (
    .CCLK(clk), .RST_N(rst1_n), .BTN_STEP(btn_step1), .BTN_RUN(btn_run1),
    .BP_EN(bp_en1), .BP_ADDR(bp_addr1), .PC(pc1),
    .CPU_EN(cpu_en1), .MODE(mode1), .STEP_CNT(step_cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int c, input logic [31:0] cnt, input logic [1:0] m, input logic [31:0] p);
    exp_t e;
    e.cyc = c; e.cnt = cnt; e.mode = m; e.pc = p;
    sbq.push_back(e);
  endtask

  task automatic push_run(input int c, input int n, input logic [31:0] cnt0,
                          input logic [31:0] pc0, input logic [31:0] pcs);
    for (int k = 0; k < n; k++) push(c + 2 * k, cnt0 + k, MODE_RUN, pc0 + pcs * k);
  endtask

  // Monitor: every CPU_EN pulse must match the next expected pulse; then the pipeline model advances.
  always @(negedge clk) begin
    if (cpu_en === 1'b1) begin
      chk("pulse_expected", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        exp_t e;
        e = sbq.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_cnt", step_cnt, e.cnt);
        chk("pulse_mode", {30'd0, mode}, {30'd0, e.mode});
        chk("pulse_pc", pc, e.pc);
      end
      if (pc_adv) pc = pc + 32'd4;
    end
  end

  initial begin
    int c;
    rst_n = 1'b0; btn_step = 1'b0; btn_run = 1'b0; bp_en = 1'b0; bp_addr = '0; pc = '0;
    rst1_n = 1'b0; btn_step1 = 1'b0; btn_run1 = 1'b0; bp_en1 = 1'b0; bp_addr1 = '0; pc1 = '0;
    tick(3);
    chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("rst_mode", {30'd0, mode}, {30'd0, MODE_STEP});
    chk("rst_step_cnt", step_cnt, 32'd0);
    chk("rst1_step_cnt", step_cnt1, 32'd0);
    rst_n = 1'b1; rst1_n = 1'b1;
    tick(2);

    // Clean single-step press: one pulse 7 cycles after the first sampling edge.
    c = cyc; push(c + 7, 32'd1, MODE_STEP, 32'h0);
    btn_step = 1'b1; tick(20); btn_step = 1'b0; tick(10);
    chk("t1_mode", {30'd0, mode}, {30'd0, MODE_STEP});
    chk("t1_cnt", step_cnt, 32'd1);

    // Bouncing step button, then steady high.
    for (int i = 0; i < 3; i++) begin
      btn_step = 1'b1; tick(2); btn_step = 1'b0; tick(2);
    end
    c = cyc; push(c + 7, 32'd2, MODE_STEP, 32'h4);
    btn_step = 1'b1; tick(20); btn_step = 1'b0; tick(10);
    chk("t2_cnt", step_cnt, 32'd2);

    // Free run at RUN_DIV=2 with PC held and no breakpoint, then stop.
    pc_adv = 1'b0; pc = 32'h10;
    c = cyc; push_run(c + 9, 21, 32'd3, 32'h10, 32'd0);
    btn_run = 1'b1; tick(20);
    chk("t3_mode_run", {30'd0, mode}, {30'd0, MODE_RUN});
    btn_run = 1'b0; tick(23);
    btn_run = 1'b1; tick(20); btn_run = 1'b0; tick(20);
    chk("t3_mode_stop", {30'd0, mode}, {30'd0, MODE_STEP});
    chk("t3_cnt", step_cnt, 32'd23);

    // Breakpoint at 0x0C with an advancing PC.
    pc_adv = 1'b1; pc = 32'h0; bp_en = 1'b1; bp_addr = 32'h0C;
    c = cyc;
    push(c + 9, 32'd24, MODE_RUN, 32'h0);
    push(c + 11, 32'd25, MODE_RUN, 32'h4);
    push(c + 13, 32'd26, MODE_RUN, 32'h8);
    btn_run = 1'b1; tick(20); btn_run = 1'b0;
    chk("t4_mode_break", {30'd0, mode}, {30'd0, MODE_BREAK});
    chk("t4_cnt_break", step_cnt, 32'd26);
    tick(10); bp_en = 1'b0; tick(10);
    chk("t4_break_bp_off", {30'd0, mode}, {30'd0, MODE_BREAK});
    chk("t4_break_no_en", {31'd0, cpu_en}, 32'd0);
    bp_en = 1'b1;

    c = cyc; push(c + 7, 32'd27, MODE_STEP, 32'h0C);
    btn_step = 1'b1; tick(20); btn_step = 1'b0; tick(10);
    chk("t4_step_mode", {30'd0, mode}, {30'd0, MODE_STEP});

    pc = 32'h0;
    c = cyc;
    push(c + 9, 32'd28, MODE_RUN, 32'h0);
    push(c + 11, 32'd29, MODE_RUN, 32'h4);
    push(c + 13, 32'd30, MODE_RUN, 32'h8);
    btn_run = 1'b1; tick(20); btn_run = 1'b0; tick(10);
    chk("t4_mode_break2", {30'd0, mode}, {30'd0, MODE_BREAK});
    chk("t4_cnt_break2", step_cnt, 32'd30);

    c = cyc; push_run(c + 9, 21, 32'd31, 32'h0C, 32'd4);
    btn_run = 1'b1; tick(20); btn_run = 1'b0; tick(23);
    btn_run = 1'b1; tick(20); btn_run = 1'b0; tick(20);
    chk("t4_resume_mode", {30'd0, mode}, {30'd0, MODE_STEP});
    chk("t4_resume_cnt", step_cnt, 32'd51);

    // Both buttons in the same cycle: run wins, no step pulse.
    pc_adv = 1'b0; pc = 32'h100; bp_en = 1'b0;
    c = cyc;
    btn_step = 1'b1; btn_run = 1'b1; tick(8);
    chk("t5_mode", {30'd0, mode}, {30'd0, MODE_RUN});
    chk("t5_cnt_hold", step_cnt, 32'd51);
    chk("t5_no_en", {31'd0, cpu_en}, 32'd0);
    push_run(c + 9, 21, 32'd52, 32'h100, 32'd0);
    tick(12); btn_step = 1'b0; btn_run = 1'b0; tick(23);
    btn_run = 1'b1; tick(20); btn_run = 1'b0; tick(20);
    chk("t5_mode_stop", {30'd0, mode}, {30'd0, MODE_STEP});
    chk("t5_cnt", step_cnt, 32'd72);

    // RUN_DIV=1: back-to-back pulses, counter wrap, then asynchronous reset mid-run.
    btn_run1 = 1'b1; tick(10);
    chk("t6_en_run", {31'd0, cpu_en1}, 32'd1);
    chk("t6_mode_run", {30'd0, mode1}, {30'd0, MODE_RUN});
    chk("t6_cnt_run", step_cnt1, 32'd3);
    tick(1);
    chk("t6_en_consec", {31'd0, cpu_en1}, 32'd1);
    chk("t6_cnt_consec", step_cnt1, 32'd4);
    btn_run1 = 1'b0;
    force dut1.step_cnt_q = 32'hFFFF_FFFE;
    #1 release dut1.step_cnt_q;
    tick(1);
    chk("t6_cnt_max", step_cnt1, 32'hFFFF_FFFF);
    tick(1);
    chk("t6_cnt_wrap", step_cnt1, 32'h0);
    tick(2);
    rst1_n = 1'b0;
    #1;
    chk("t6_rst_en", {31'd0, cpu_en1}, 32'd0);
    chk("t6_rst_mode", {30'd0, mode1}, {30'd0, MODE_STEP});
    chk("t6_rst_cnt", step_cnt1, 32'd0);
    tick(1); rst1_n = 1'b1; tick(5);
    chk("t6_post_en", {31'd0, cpu_en1}, 32'd0);
    chk("t6_post_mode", {30'd0, mode1}, {30'd0, MODE_STEP});
    chk("t6_post_cnt", step_cnt1, 32'd0);

    chk("sb_drain", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
